uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Parametrised command controller between the UART receiver, an external combinational ALU and the UART transmitter. It decodes two-byte frames (header, payload) from the RX byte stream into operand A, operand B and opcode registers. An opcode frame triggers one ALU evaluation, and the result is transmitted back through the TX handshake. Compared with the first-generation interface it adds a returned-result TX path, payload timeout, error reporting, a busy indication and an optional checksum byte.

## Interface
- NB_DATA, 8, data/operand/result width in bits; RX/TX byte width equals NB_DATA
- NB_OP, 6, opcode width; taken from payload[NB_OP-1:0]
- HDR_A, 8'h08, header code: load operand A
- HDR_B, 8'h10, header code: load operand B
- HDR_OP, 8'h20, header code: load opcode and execute
- TIMEOUT_CYC, 1024, max idle cycles while waiting for a payload or check byte; 0 disables the timeout
- clk  in  1  clock
- i_rst_n  in  1  reset i_rst_n, asynchronous, active-low; clock clk
- i_rx_data  in  NB_DATA  received byte; valid only when i_rx_done=1
- i_rx_done  in  1  single-cycle pulse, one per received byte
- i_tx_done  in  1  single-cycle pulse, TX finished the last byte
- i_alu_result  in  NB_DATA  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
- o_alu_a, o_alu_b  out  NB_DATA  operand registers
- o_alu_op  out  NB_OP  opcode register
- o_alu_valid  out  1  one-cycle execute strobe
- o_tx_data  out  NB_DATA  result byte; held until the next result
- o_tx_start  out  1  one-cycle TX start pulse
- o_busy  out  1  high in EXEC, SEND and WAIT_TX
- o_err  out  1  one-cycle error pulse
- o_err_code  out  2  00 bad header, 01 timeout, 10 overrun, 11 checksum; meaningful only while o_err=1

## Operation
- FSM states: IDLE, PAYLOAD, CHECK (only when checksum is enabled), EXEC, SEND, WAIT_TX. Reset state is IDLE.
- IDLE:
  - i_rx_done with a byte equal to HDR_A, HDR_B or HDR_OP: latch the header, clear the timeout counter, go to PAYLOAD.
  - i_rx_done with any other byte: o_err pulse, code 00, stay in IDLE.
- PAYLOAD on i_rx_done:
  - Latch the payload into a staging register.
  - Without checksum: commit immediately. A or B returns to IDLE; OP goes to EXEC.
  - With checksum: go to CHECK.
- Commit rules:
  - A writes o_alu_a; B writes o_alu_b; OP writes o_alu_op.
  - Registers not addressed by the frame keep their values.
- EXEC: o_alu_valid=1 for this single cycle; i_alu_result is captured into o_tx_data at the end of the cycle; go to SEND.
- SEND: o_tx_start=1 for one cycle; go to WAIT_TX.
- WAIT_TX: wait with no bound; i_tx_done returns to IDLE.
- Timeout:
  - Counter counts cycles in PAYLOAD/CHECK without i_rx_done.
  - On reaching TIMEOUT_CYC: discard the frame, o_err code 01, go to IDLE.
  - i_rx_done in the same cycle as expiry takes priority over the timeout.
  - The counter clears on every accepted byte.
- Overrun: i_rx_done while in EXEC, SEND or WAIT_TX drops the byte and pulses o_err with code 10; the state is unaffected.
- i_tx_done outside WAIT_TX is ignored.
- Reset mid-frame or mid-TX: the FSM returns to IDLE, the partial frame is lost and no o_tx_start is issued.
- All outputs reset to 0, including the operand registers, opcode and o_tx_data.

## Timing
- Header i_rx_done at cycle N: state is PAYLOAD at N+1.
- A/B payload i_rx_done at cycle M: o_alu_a/o_alu_b updated and state IDLE at M+1.
- OP payload i_rx_done at cycle M: o_alu_op updated and o_alu_valid=1 at M+1; o_tx_start=1 and o_tx_data valid at M+2; o_busy high from M+1 until the cycle after i_tx_done.
- With checksum enabled, M is the check-byte cycle instead of the payload cycle.
- Back-to-back frames: the next header is accepted in the first cycle after the FSM returns to IDLE.
- o_err is registered and asserted the cycle after the offending event.

## Configuration
- Macro UART_ALU_CTRL_CHECKSUM_EN.
- Defined:
  - Each frame is three bytes: header, payload, check.
  - The check byte must equal header XOR payload.
  - On a match, the payload is committed in CHECK.
  - On a mismatch, the frame is discarded, o_err code 11 is pulsed and the FSM goes to IDLE.
  - The timeout also applies in CHECK.
- Undefined: the CHECK state and code 11 do not exist, and frames are two bytes.

## Test plan
- Reset, then bytes 08,05 / 10,03 / 20,00 with the bench ALU computing a+b: o_alu_a=5, o_alu_b=3, o_alu_op=0, one o_alu_valid pulse, o_tx_start with o_tx_data=8 two cycles after the last i_rx_done; i_tx_done returns the FSM to IDLE with o_busy low.
- Byte 55 in IDLE: o_err=1 with code 00, no register changes; a following 08,7F loads o_alu_a=7F.
- Byte 08, then no byte for TIMEOUT_CYC cycles: o_err code 01, FSM in IDLE, o_alu_a unchanged.
- Byte 0A received while in WAIT_TX: o_err code 10, byte dropped, no second o_tx_start, TX completion unaffected.
- Checksum enabled: 08,05,0D loads A=5; 08,05,00 gives o_err code 11 and A unchanged.
- Reset asserted after the OP payload, before SEND: all outputs 0, no o_tx_start, and a new frame decodes normally after release.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frame decoder between the UART RX byte stream, an external
// combinational ALU and the UART TX handshake.
//
// Frames are <header><payload>, or <header><payload><check> when the
// optional checksum is built in (macro UART_ALU_CTRL_CHECKSUM_EN). An opcode
// frame triggers one ALU evaluation whose result is sent back over TX.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a header byte; unknown bytes pulse a 00 error
// ST_PAYLOAD | header latched, waiting for the payload byte (timeout armed)
// ST_CHECK   | payload staged, waiting for the check byte (checksum only)
// ST_EXEC    | one-cycle ALU execute strobe, result captured into o_tx_data
// ST_SEND    | one-cycle TX start pulse
// ST_WAIT_TX | waiting, without bound, for the TX done pulse
//
// Bytes arriving in EXEC/SEND/WAIT_TX are dropped with a 10 (overrun) error.

module uart_alu_ctrl #(
   parameter int                 NB_DATA     = 8,
   parameter int                 NB_OP       = 6,
   parameter logic [NB_DATA-1:0] HDR_A       = 8'h08,
   parameter logic [NB_DATA-1:0] HDR_B       = 8'h10,
   parameter logic [NB_DATA-1:0] HDR_OP      = 8'h20,
   parameter int                 TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_done,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic               o_alu_valid,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_err,
   output logic [1:0]         o_err_code
);

   localparam logic [1:0] ERR_HDR = 2'b00;
   localparam logic [1:0] ERR_TMO = 2'b01;
   localparam logic [1:0] ERR_OVR = 2'b10;
`ifdef UART_ALU_CTRL_CHECKSUM_EN
   localparam logic [1:0] ERR_CHK = 2'b11;
`endif

   // Timeout is a down-counter loaded with TIMEOUT_CYC-1 on every accepted
   // byte; an idle cycle seen with the counter at zero is the expiry cycle.
   localparam bit            TMO_EN   = (TIMEOUT_CYC != 0);
   localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PAYLOAD = 3'd1,
      ST_EXEC    = 3'd2,
      ST_SEND    = 3'd3,
      ST_WAIT_TX = 3'd4
`ifdef UART_ALU_CTRL_CHECKSUM_EN
      , ST_CHECK = 3'd5
`endif
   } state_t;

   state_t             state;
   state_t             state_n;
   logic [NB_DATA-1:0] hdr_q;
   logic [TW-1:0]      tmo_cnt;
   logic               tmo_exp;
   logic               in_wait;
   logic               is_hdr;
   logic               hdr_accept;
   logic               commit_en;
   logic [NB_DATA-1:0] commit_val;
   logic               err_set;
   logic [1:0]         err_code_n;

`ifdef UART_ALU_CTRL_CHECKSUM_EN
   logic [NB_DATA-1:0] payload_q;
   logic               chk_ok;

   assign chk_ok     = (i_rx_data == (hdr_q ^ payload_q));
   assign commit_val = payload_q;
   assign in_wait    = (state == ST_PAYLOAD) || (state == ST_CHECK);
`else
   assign commit_val = i_rx_data;
   assign in_wait    = (state == ST_PAYLOAD);
`endif

   assign is_hdr  = (i_rx_data == HDR_A) || (i_rx_data == HDR_B) || (i_rx_data == HDR_OP);
   assign tmo_exp = TMO_EN && (tmo_cnt == '0) && !i_rx_done;

   // State register.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode, plus the frame commit and error events it implies.
   always_comb begin
      state_n    = state;
      hdr_accept = 1'b0;
      commit_en  = 1'b0;
      err_set    = 1'b0;
      err_code_n = ERR_HDR;
      case (state)
         ST_IDLE: begin
            if (i_rx_done) begin
               if (is_hdr) begin
                  hdr_accept = 1'b1;
                  state_n    = ST_PAYLOAD;
               end else begin
                  err_set    = 1'b1;
                  err_code_n = ERR_HDR;
               end
            end
         end
         ST_PAYLOAD: begin
            if (i_rx_done) begin
`ifdef UART_ALU_CTRL_CHECKSUM_EN
               state_n = ST_CHECK;
`else
               commit_en = 1'b1;
               state_n   = (hdr_q == HDR_OP) ? ST_EXEC : ST_IDLE;
`endif
            end else if (tmo_exp) begin
               err_set    = 1'b1;
               err_code_n = ERR_TMO;
               state_n    = ST_IDLE;
            end
         end
`ifdef UART_ALU_CTRL_CHECKSUM_EN
         ST_CHECK: begin
            if (i_rx_done) begin
               if (chk_ok) begin
                  commit_en = 1'b1;
                  state_n   = (hdr_q == HDR_OP) ? ST_EXEC : ST_IDLE;
               end else begin
                  err_set    = 1'b1;
                  err_code_n = ERR_CHK;
                  state_n    = ST_IDLE;
               end
            end else if (tmo_exp) begin
               err_set    = 1'b1;
               err_code_n = ERR_TMO;
               state_n    = ST_IDLE;
            end
         end
`endif
         ST_EXEC: begin
            state_n = ST_SEND;
            if (i_rx_done) begin
               err_set    = 1'b1;
               err_code_n = ERR_OVR;
            end
         end
         ST_SEND: begin
            state_n = ST_WAIT_TX;
            if (i_rx_done) begin
               err_set    = 1'b1;
               err_code_n = ERR_OVR;
            end
         end
         ST_WAIT_TX: begin
            if (i_tx_done) begin
               state_n = ST_IDLE;
            end
            if (i_rx_done) begin
               err_set    = 1'b1;
               err_code_n = ERR_OVR;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      o_alu_valid = (state == ST_EXEC);
      o_tx_start  = (state == ST_SEND);
      o_busy      = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);
   end

   // Payload-wait timer: reload on each accepted byte, count down while idle.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt <= '0;
      end else if (i_rx_done && ((state == ST_IDLE) || (state == ST_PAYLOAD))) begin
         tmo_cnt <= TMO_LOAD;
      end else if (in_wait && (tmo_cnt != '0)) begin
         tmo_cnt <= tmo_cnt - TW'(1);
      end
   end

   // Frame registers, operand/opcode commit, TX result capture and error flag.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hdr_q      <= '0;
         o_alu_a    <= '0;
         o_alu_b    <= '0;
         o_alu_op   <= '0;
         o_tx_data  <= '0;
         o_err      <= 1'b0;
         o_err_code <= 2'b00;
`ifdef UART_ALU_CTRL_CHECKSUM_EN
         payload_q  <= '0;
`endif
      end else begin
         if (hdr_accept) begin
            hdr_q <= i_rx_data;
         end
`ifdef UART_ALU_CTRL_CHECKSUM_EN
         if ((state == ST_PAYLOAD) && i_rx_done) begin
            payload_q <= i_rx_data;
         end
`endif
         if (commit_en) begin
            if (hdr_q == HDR_A) begin
               o_alu_a <= commit_val;
            end
            if (hdr_q == HDR_B) begin
               o_alu_b <= commit_val;
            end
            if (hdr_q == HDR_OP) begin
               o_alu_op <= commit_val[NB_OP-1:0];
            end
         end
         if (state == ST_EXEC) begin
            o_tx_data <= i_alu_result;
         end
         o_err      <= err_set;
         o_err_code <= err_code_n;
      end
   end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: directed frames, with a scoreboard queue of
// expected execute/TX-start/error events checked by an independent monitor,
// plus directed register and timing checks.

module tb_uart_alu_ctrl;

   localparam int TMO = 1024;
   localparam logic [7:0] K_VALID = 8'd1;
   localparam logic [7:0] K_START = 8'd2;
   localparam logic [7:0] K_ERR   = 8'd3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] alu_result;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic       alu_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;
   logic       err;
   logic [1:0] err_code;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] sb_q[$];

   uart_alu_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk          (clk),
      .i_rst_n      (rst_n),
      .i_rx_data    (rx_data),
      .i_rx_done    (rx_done),
      .i_tx_done    (tx_done),
      .i_alu_result (alu_result),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_op     (alu_op),
      .o_alu_valid  (alu_valid),
      .o_tx_data    (tx_data),
      .o_tx_start   (tx_start),
      .o_busy       (busy),
      .o_err        (err),
      .o_err_code   (err_code)
   );

   // Bench ALU: 0 add, 1 subtract, otherwise xor.
   assign alu_result = (alu_op == 6'd0) ? alu_a + alu_b :
                       (alu_op == 6'd1) ? alu_a - alu_b : alu_a ^ alu_b;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic expect_ev(input logic [7:0] kind, input logic [7:0] val);
      sb_q.push_back({kind, val});
   endtask

   task automatic sb_pop(input string name, input logic [7:0] kind, input logic [7:0] val);
      logic [15:0] e;
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: unexpected event value %0h, nothing expected", name, val);
      end else begin
         e = sb_q.pop_front();
         chk(name, {kind, val}, e);
      end
   endtask

   // Monitor: every DUT event is matched against the scoreboard in fixed order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (alu_valid) sb_pop("sb_alu_valid", K_VALID, {2'b00, alu_op});
         if (tx_start)  sb_pop("sb_tx_start", K_START, tx_data);
         if (err)       sb_pop("sb_err", K_ERR, {6'd0, err_code});
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [7:0] pl);
      send_byte(hdr);
      send_byte(pl);
`ifdef UART_ALU_CTRL_CHECKSUM_EN
      send_byte(hdr ^ pl);
`endif
   endtask

   task automatic pulse_tx_done();
      @(posedge clk); #1;
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      chk("rst_op", alu_op, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_alu_valid", alu_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic A/B/OP sequence, add.
      send_frame(8'h08, 8'h05);
      chk("load_a", alu_a, 8'h05);
      chk("idle_after_a", busy, 0);
      send_frame(8'h10, 8'h03);
      chk("load_b", alu_b, 8'h03);
      chk("a_kept", alu_a, 8'h05);
      expect_ev(K_VALID, 8'h00);
      expect_ev(K_START, 8'h08);
      send_frame(8'h20, 8'h00);
      chk("op_loaded", alu_op, 0);
      chk("exec_valid", alu_valid, 1);
      chk("exec_busy", busy, 1);
      @(posedge clk); #1;
      chk("send_start", tx_start, 1);
      chk("send_data", tx_data, 8'h08);
      chk("send_no_valid", alu_valid, 0);
      @(posedge clk); #1;
      chk("wait_start_low", tx_start, 0);
      chk("wait_busy", busy, 1);
      pulse_tx_done();
      chk("tx_done_idle", busy, 0);

      // Bad header.
      expect_ev(K_ERR, 8'h00);
      send_byte(8'h55);
      chk("badhdr_err", err, 1);
      chk("badhdr_code", err_code, 2'b00);
      chk("badhdr_a", alu_a, 8'h05);
      send_frame(8'h08, 8'h7F);
      chk("load_a_7f", alu_a, 8'h7F);

      // Payload timeout.
      expect_ev(K_ERR, 8'h01);
      send_byte(8'h08);
      repeat (TMO - 1) @(posedge clk);
      #1;
      chk("tmo_not_early", err, 0);
      @(posedge clk); #1;
      chk("tmo_err", err, 1);
      chk("tmo_code", err_code, 2'b01);
      chk("tmo_a_kept", alu_a, 8'h7F);
      send_frame(8'h10, 8'h44);
      chk("tmo_idle_a", alu_a, 8'h7F);
      chk("tmo_idle_b", alu_b, 8'h44);

      // Overrun during WAIT_TX, subtract.
      expect_ev(K_VALID, 8'h01);
      expect_ev(K_START, 8'h3B);
      send_frame(8'h20, 8'h01);
      chk("ovr_exec_valid", alu_valid, 1);
      @(posedge clk); #1;
      chk("ovr_tx_data", tx_data, 8'h3B);
      expect_ev(K_ERR, 8'h02);
      send_byte(8'h0A);
      chk("ovr_err", err, 1);
      chk("ovr_code", err_code, 2'b10);
      chk("ovr_busy", busy, 1);
      chk("ovr_no_start", tx_start, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("ovr_still_wait", busy, 1);
      pulse_tx_done();
      chk("ovr_done_idle", busy, 0);
      chk("ovr_op_kept", alu_op, 1);
      chk("ovr_a_kept", alu_a, 8'h7F);

      // TX done while idle has no effect.
      pulse_tx_done();
      chk("txdone_idle_busy", busy, 0);
      send_frame(8'h08, 8'h11);
      chk("after_stray_txdone", alu_a, 8'h11);

      // Reset between execute and send.
      expect_ev(K_VALID, 8'h02);
      send_frame(8'h20, 8'h02);
      chk("pre_rst_valid", alu_valid, 1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", alu_valid, 0);
      chk("midrst_a", alu_a, 0);
      chk("midrst_b", alu_b, 0);
      chk("midrst_op", alu_op, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_start", tx_start, 0);
      chk("midrst_tx_data", tx_data, 0);
      chk("midrst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(8'h08, 8'h09);
      send_frame(8'h10, 8'h02);
      expect_ev(K_VALID, 8'h00);
      expect_ev(K_START, 8'h0B);
      send_frame(8'h20, 8'h00);
      @(posedge clk); #1;
      chk("postrst_start", tx_start, 1);
      chk("postrst_data", tx_data, 8'h0B);
      pulse_tx_done();
      chk("postrst_idle", busy, 0);

`ifdef UART_ALU_CTRL_CHECKSUM_EN
      send_byte(8'h08);
      send_byte(8'h05);
      send_byte(8'h0D);
      chk("cks_good_a", alu_a, 8'h05);
      expect_ev(K_ERR, 8'h03);
      send_byte(8'h08);
      send_byte(8'h05);
      send_byte(8'h00);
      chk("cks_bad_err", err, 1);
      chk("cks_bad_code", err_code, 2'b11);
      chk("cks_bad_a", alu_a, 8'h05);
      chk("cks_bad_idle", busy, 0);
`endif

      repeat (5) @(posedge clk);
      #1;
      chk("sb_drain", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
